// File: rtl/mc_control_fsm.sv
// Multi-cycle control FSM for the 8-bit CPU: fetch/decode/exec/mem/wb
// with independent imem/dmem busywait stalls and a memory watchdog.
module mc_control_fsm #(
    parameter int OPCODE_W  = 8,
    parameter int ALU_SEL_W = 3,
    parameter int TIMEOUT   = 255
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic [OPCODE_W-1:0]  opcode,
    input  logic                 zero,
    input  logic                 busywait_i,
    input  logic                 busywait_d,
    output logic                 imem_read,
    output logic                 ir_load,
    output logic                 dmem_read,
    output logic                 dmem_write,
    output logic                 reg_write,
    output logic                 wb_mem,
    output logic [ALU_SEL_W-1:0] alu_sel,
    output logic                 src_imm,
    output logic                 src_neg,
    output logic                 pc_write,
    output logic                 pc_sel,
    output logic                 mem_err,
    output logic                 illegal
);

    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB} state_t;

    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    state_t              state_q, state_n;
    logic [OPCODE_W-1:0] op_q;
    logic [CNT_W-1:0]    wd_q, wd_n;

    logic [3:0]           low;
    logic                 legal;
    logic                 is_alu, is_load, is_store;
    logic                 is_j, is_beq, is_bne;
    logic [ALU_SEL_W-1:0] alu_code;
    logic                 imm_code, neg_code;
    logic                 hit, abort;

    assign low   = op_q[3:0];
    assign legal = ((op_q >> 4) == '0) && (low <= 4'd12);
    assign hit   = (TIMEOUT != 0) && (wd_q == CNT_W'(TIMEOUT));

    always_comb begin
        is_alu   = legal && (low <= 4'd5);
        is_j     = legal && (low == 4'd6);
        is_beq   = legal && (low == 4'd7);
        is_bne   = legal && (low == 4'd12);
        is_load  = legal && (low == 4'd8 || low == 4'd9);
        is_store = legal && (low == 4'd10 || low == 4'd11);
        imm_code = legal && (low == 4'd0 || low == 4'd9 || low == 4'd11);
        neg_code = legal && (low == 4'd3 || is_beq || is_bne);
        alu_code = '0;
        unique case (1'b1)
            legal && (low == 4'd2 || low == 4'd3): alu_code = ALU_SEL_W'(1);
            is_beq || is_bne:                      alu_code = ALU_SEL_W'(1);
            legal && (low == 4'd4):                alu_code = ALU_SEL_W'(2);
            legal && (low == 4'd5):                alu_code = ALU_SEL_W'(3);
            is_j:                                  alu_code = ALU_SEL_W'(4);
            default:                               alu_code = '0;
        endcase
    end

    always_comb begin
        state_n    = state_q;
        abort      = 1'b0;
        imem_read  = 1'b0;
        ir_load    = 1'b0;
        dmem_read  = 1'b0;
        dmem_write = 1'b0;
        reg_write  = 1'b0;
        wb_mem     = 1'b0;
        alu_sel    = '0;
        src_imm    = 1'b0;
        src_neg    = 1'b0;
        pc_write   = 1'b0;
        pc_sel     = 1'b0;
        mem_err    = 1'b0;
        illegal    = 1'b0;
        if (!RESET) begin
            if (state_q == EXEC || state_q == MEM || state_q == WB) begin
                alu_sel = alu_code;
                src_imm = imm_code;
                src_neg = neg_code;
            end
            unique case (state_q)
                FETCH: begin
                    if (busywait_i && hit) begin
                        abort   = 1'b1;
                        mem_err = 1'b1;
                    end else begin
                        imem_read = 1'b1;
                        if (!busywait_i) begin
                            ir_load = 1'b1;
                            state_n = DECODE;
                        end
                    end
                end
                DECODE: state_n = EXEC;
                EXEC: begin
                    unique case (1'b1)
                        is_alu: state_n = WB;
                        is_load || is_store: state_n = MEM;
                        is_j || is_beq || is_bne: begin
                            pc_write = 1'b1;
                            pc_sel   = is_j | (is_beq & zero) | (is_bne & ~zero);
                            state_n  = FETCH;
                        end
                        default: begin
                            illegal  = 1'b1;
                            pc_write = 1'b1;
                            state_n  = FETCH;
                        end
                    endcase
                end
                MEM: begin
                    if (busywait_d && hit) begin
                        abort    = 1'b1;
                        mem_err  = 1'b1;
                        pc_write = 1'b1;
                        state_n  = FETCH;
                    end else begin
                        dmem_read  = is_load;
                        dmem_write = is_store;
                        if (!busywait_d) begin
                            pc_write = is_store;
                            state_n  = is_load ? WB : FETCH;
                        end
                    end
                end
                WB: begin
                    reg_write = 1'b1;
                    wb_mem    = is_load;
                    pc_write  = 1'b1;
                    state_n   = FETCH;
                end
                default: state_n = FETCH;
            endcase
        end
    end

    // FETCH abort stays in FETCH, so abort must clear the count explicitly
    always_comb begin
        wd_n = '0;
        if (state_n == state_q && !abort &&
            ((state_q == FETCH && busywait_i) ||
             (state_q == MEM && busywait_d)))
            wd_n = wd_q + CNT_W'(1);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= FETCH;
            op_q    <= '0;
            wd_q    <= '0;
        end else begin
            state_q <= state_n;
            wd_q    <= wd_n;
            if (state_q == DECODE)
                op_q <= opcode;
        end
    end

endmodule
